spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame width in bits; only 8 is supported.
REQ-002 SHALL have port i_clk  input  1  system clock, rising-edge active; single clock domain.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_sclk  input  1  SPI serial clock from the controller, asynchronous to i_clk.
REQ-005 SHALL have port i_cs_n  input  1  chip select, active-low, asynchronous.
REQ-006 SHALL have port i_mosi  input  1  serial data in, asynchronous.
REQ-007 SHALL have port o_miso  output  1  serial data out.
REQ-008 SHALL have port i_tx_data  input  8  byte to transmit.
REQ-009 SHALL have port i_tx_load_n  input  1  active-low strobe that captures i_tx_data.
REQ-010 SHALL have port o_tx_ready  output  1  TX holding buffer is empty.
REQ-011 SHALL have port o_rx_data  output  8  last complete received byte.
REQ-012 SHALL have port o_rx_valid  output  1  one-cycle pulse when o_rx_data updates.
REQ-013 SHALL have port o_busy  output  1  a frame window is active (chip select asserted).

Function
REQ-014 SHALL pass i_sclk, i_cs_n and i_mosi through 2-flop synchronizers; synchronizer reset values are 0, 1 and 0.
REQ-015 SHALL detect SCLK edges and CS edges by comparing synchronizer stage 2 with a third registered stage.
REQ-016 SHALL operate in SPI mode 0 (CPOL=0, CPHA=0), MSB first: sample MOSI on SCLK rise, shift MISO on SCLK fall.
REQ-017 SHALL support SCLK high and low phases of at least 2 i_clk cycles each; behaviour at faster SCLK is undefined.
REQ-018 SHALL implement states IDLE and ACTIVE: IDLE->ACTIVE on synchronized CS fall; ACTIVE->IDLE on synchronized CS rise.
REQ-019 SHALL on IDLE->ACTIVE clear the bit counter to 0, load the TX shift register from the holding buffer (0x00 if empty), and drive o_miso with bit 7 in that same cycle.
REQ-020 SHALL in ACTIVE on each SCLK rise shift the synchronized MOSI into the RX shift register LSB and increment the 3-bit bit counter, which wraps from 7 to 0.
REQ-021 SHALL on the 8th SCLK rise (counter 7->0) write the full byte to o_rx_data and pulse o_rx_valid high for exactly one cycle, on the cycle after the edge is detected.
REQ-022 SHALL make o_rx_valid rise at most 4 i_clk cycles after the 8th SCLK rise at the pin.
REQ-023 SHALL in ACTIVE on each SCLK fall with counter != 0 shift the TX register left and drive o_miso with its new MSB.
REQ-024 SHALL on an SCLK fall with counter == 0 after a completed byte reload the TX register from the holding buffer (0x00 if empty), allowing back-to-back bytes within one CS window.
REQ-025 SHALL drive o_miso to 0 in IDLE.
REQ-026 SHALL hold o_busy high exactly while the state is ACTIVE.
REQ-027 SHALL capture i_tx_data into the holding buffer when i_tx_load_n is 0 and o_tx_ready is 1, with o_tx_ready falling the next cycle.
REQ-028 SHALL ignore i_tx_load_n while o_tx_ready is 0; the buffer is not overwritten.
REQ-029 SHALL set o_tx_ready to 1 the cycle after the buffer is transferred into the TX shift register.
REQ-030 SHALL, when a load and a buffer transfer occur in the same cycle, transfer the old contents first (0x00 if empty), store the new byte and keep o_tx_ready at 0.
REQ-031 SHALL on CS rise mid-byte (counter != 0) discard the partial RX byte, produce no o_rx_valid pulse and return to IDLE; a loaded buffer not yet transferred is retained.
REQ-032 SHALL on simultaneous synchronized CS rise and SCLK rise give the CS rise priority, so no sample is taken.
REQ-033 SHALL keep o_rx_data unchanged except on a completed byte.

Reset
REQ-034 SHALL while i_rst_n is 0 force o_miso=0, o_rx_data=0x00, o_rx_valid=0, o_tx_ready=1, o_busy=0, state IDLE, counter 0, buffers 0x00, and synchronizers to their REQ-014 values.
REQ-035 SHALL, on reset asserted mid-frame, drop the frame with no o_rx_valid pulse, and after release remain in IDLE until a new synchronized CS fall.

Verification
REQ-036 SHALL be covered by a bench case: reset for 16 cycles with i_cs_n=1 -> all outputs at their REQ-034 values, o_tx_ready=1.
REQ-037 SHALL be covered by a bench case: load 0xA5, CS low, 8 SCLK periods of 8 i_clk cycles with MOSI=0x3C, CS high -> o_miso bits 1,0,1,0,0,1,0,1; o_rx_data=0x3C; exactly one o_rx_valid pulse; o_tx_ready back to 1.
REQ-038 SHALL be covered by a bench case: SCLK at minimum 4-cycle period, two back-to-back bytes 0x81 and 0x7E in one CS window with buffer reloaded to 0xC3 between -> two o_rx_valid pulses; MISO carries the first buffer byte then 0xC3.
REQ-039 SHALL be covered by a bench case: CS raised after 5 SCLK rises -> no o_rx_valid pulse, o_rx_data unchanged, o_busy=0 within 4 cycles.
REQ-040 SHALL be covered by a bench case: frame with no load -> MISO all 0 (0x00); a load attempted while o_tx_ready=0 is ignored and the first buffer byte is sent.
REQ-041 SHALL be covered by a bench case: i_rst_n pulsed low after the 3rd SCLK rise -> no o_rx_valid pulse, o_rx_data=0x00, state IDLE until the next CS fall.

Source files
------------

// File: rtl/spi_peripheral.sv
// ----------------------------------------------------------------------------
// spi_peripheral
//
// SPI mode-0 (CPOL=0, CPHA=0), MSB-first peripheral, oversampled by i_clk.
// SCLK, CS_N and MOSI are brought into the i_clk domain through 2-flop
// synchronizers; a third registered stage on SCLK and CS_N provides edge
// detection. A one-byte TX holding buffer feeds the TX shift register at
// frame start and after every completed byte, so a host can stream
// back-to-back bytes inside one chip-select window.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_sclk       SPI clock from controller (asynchronous)
//   i_cs_n       SPI chip select, active low (asynchronous)
//   i_mosi       SPI data in (asynchronous)
//   o_miso       SPI data out, 0 while idle
//   i_tx_data    byte to transmit
//   i_tx_load_n  active-low strobe capturing i_tx_data into the buffer
//   o_tx_ready   holding buffer empty
//   o_rx_data    last completely received byte
//   o_rx_valid   one-cycle pulse when o_rx_data updates
//   o_busy       chip-select window active
//
// Only DATA_W = 8 is supported.
// ----------------------------------------------------------------------------
module spi_peripheral #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_load_n,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        sclk_sync_q, sclk_sync_d;   // [0] stage 1, [1] stage 2, [2] edge stage
    logic [2:0]        cs_sync_q, cs_sync_d;
    logic [1:0]        mosi_sync_q, mosi_sync_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              byte_done_q, byte_done_d;   // a byte completed, TX reload pending

    logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic              mosi_s;
    logic              start_frame, load_accept, transfer;
    logic [DATA_W-1:0] hold_out;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], i_sclk};
        cs_sync_d   = {cs_sync_q[1:0], i_cs_n};
        mosi_sync_d = {mosi_sync_q[0], i_mosi};
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign mosi_s    = mosi_sync_q[1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every flop
            // samples the pre-edge value of every other flop.
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy = 1'b0;
        o_miso = 1'b0;
        if (state_q == ACTIVE) begin
            o_busy = 1'b1;
            o_miso = tx_shift_q[DATA_W-1];
        end
    end

    // ------------------------------------------------------------------
    // Datapath: shift registers, bit counter, holding buffer
    // ------------------------------------------------------------------
    assign start_frame = (state_q == IDLE) && cs_fall;
    assign load_accept = ~i_tx_load_n & ~hold_full_q;
    assign hold_out    = hold_full_q ? hold_q : '0;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        byte_done_d = byte_done_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        transfer    = 1'b0;

        if (start_frame) begin
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            tx_shift_d  = hold_out;
            transfer    = 1'b1;
        end else if ((state_q == ACTIVE) && !cs_rise) begin
            // A CS rise wins over a coincident SCLK edge: nothing is sampled.
            if (sclk_rise) begin
                rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    rx_data_d   = rx_shift_d;
                    rx_valid_d  = 1'b1;
                    byte_done_d = 1'b1;
                end
            end else if (sclk_fall) begin
                if (bit_cnt_q != '0) begin
                    tx_shift_d = tx_shift_q << 1;
                end else if (byte_done_q) begin
                    // Byte boundary: next byte comes from the holding buffer.
                    tx_shift_d  = hold_out;
                    byte_done_d = 1'b0;
                    transfer    = 1'b1;
                end
            end
        end

        // A load can only be accepted while the buffer is empty, so when it
        // coincides with a transfer the shift register gets 0x00 and the
        // new byte stays pending with the buffer marked full.
        if (load_accept) begin
            hold_d      = i_tx_data;
            hold_full_d = 1'b1;
        end else if (transfer) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_tx_ready = ~hold_full_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// ----------------------------------------------------------------------------
// tb_spi_peripheral
//
// Self-checking bench for spi_peripheral. Acts as an SPI mode-0 controller
// and as the local host loading TX bytes. Expected values come from a
// byte-level model: every received byte equals the MOSI byte sent, and every
// transmitted byte is whatever the holding buffer held when the frame started
// or the previous byte completed (0x00 if empty).
// All stimulus changes on the falling edge of i_clk; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_spi_peripheral;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_sclk;
    logic       i_cs_n;
    logic       i_mosi;
    logic       o_miso;
    logic [7:0] i_tx_data;
    logic       i_tx_load_n;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_busy;

    spi_peripheral #(.DATA_W(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_sclk      (i_sclk),
        .i_cs_n      (i_cs_n),
        .i_mosi      (i_mosi),
        .o_miso      (o_miso),
        .i_tx_data   (i_tx_data),
        .i_tx_load_n (i_tx_load_n),
        .o_tx_ready  (o_tx_ready),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_rise_cyc = 0;

    // Byte-level reference model of the TX holding buffer.
    logic [7:0] model_buf  = 8'h00;
    bit         model_full = 1'b0;

    // Observed receive events: data and latency from the last SCLK rise.
    logic [7:0] rx_q[$];
    int         lat_q[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_rx_valid) begin
            rx_q.push_back(o_rx_data);
            lat_q.push_back(cyc - last_rise_cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Buffer handoff: what the shift register receives, buffer becomes empty.
    function automatic logic [7:0] take_buf();
        take_buf   = model_full ? model_buf : 8'h00;
        model_full = 1'b0;
    endfunction

    // One-cycle load strobe; the model accepts it only if the buffer is empty.
    task automatic load_byte(input logic [7:0] d);
        check("tx_ready_before_load", o_tx_ready, !model_full);
        i_tx_data   = d;
        i_tx_load_n = 1'b0;
        wait_cycles(1);
        i_tx_load_n = 1'b1;
        if (!model_full) begin
            model_buf  = d;
            model_full = 1'b1;
        end
    endtask

    // Drive nbits mode-0 SCLK periods, MSB first. MISO is captured at the end
    // of each high phase, which stays inside the valid window even at the
    // minimum SCLK period given the synchronizer delay.
    task automatic drive_byte(input logic [7:0] mosi_b, input int half, input int nbits,
                              input bit do_ld, input logic [7:0] ld, output logic [7:0] miso_b);
        miso_b = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            i_mosi = mosi_b[7-i];
            wait_cycles(half);
            i_sclk = 1'b1;
            last_rise_cyc = cyc;
            if (do_ld && i == 3) begin
                load_byte(ld);
                wait_cycles(half - 1);
            end else begin
                wait_cycles(half);
            end
            miso_b[7-i] = o_miso;
            i_sclk = 1'b0;
        end
    endtask

    // A complete chip-select window of nbytes back-to-back bytes.
    task automatic run_frame(input int nbytes, input int half, input logic [23:0] mosi_bytes,
                             input logic [2:0] ld_mask, input logic [23:0] ld_bytes);
        logic [7:0] exp_tx;
        logic [7:0] got_tx;
        rx_q.delete();
        lat_q.delete();
        i_cs_n = 1'b0;
        wait_cycles(4);
        check("busy_in_frame", o_busy, 1);
        exp_tx = take_buf();
        for (int b = 0; b < nbytes; b++) begin
            drive_byte(mosi_bytes[8*b +: 8], half, 8, ld_mask[b], ld_bytes[8*b +: 8], got_tx);
            check("miso_byte", got_tx, exp_tx);
            exp_tx = take_buf();
        end
        wait_cycles(half);
        i_cs_n = 1'b1;
        wait_cycles(4);
        check("busy_after_cs_rise", o_busy, 0);
        check("rx_valid_count", rx_q.size(), nbytes);
        for (int b = 0; b < nbytes && b < rx_q.size(); b++) begin
            check("rx_byte", rx_q[b], mosi_bytes[8*b +: 8]);
            check("rx_latency_le4", lat_q[b] <= 4, 1);
        end
        check("rx_data_final", o_rx_data, mosi_bytes[8*(nbytes-1) +: 8]);
        check("tx_ready_after_frame", o_tx_ready, !model_full);
        check("miso_idle", o_miso, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_tx;
        logic [7:0] got_tx;
        logic [7:0] rx_before;
        logic [7:0] b0;

        i_rst_n     = 1'b0;
        i_sclk      = 1'b0;
        i_cs_n      = 1'b1;
        i_mosi      = 1'b0;
        i_tx_data   = 8'h00;
        i_tx_load_n = 1'b1;

        // Reset state held for 16 cycles
        wait_cycles(16);
        check("rst_miso", o_miso, 0);
        check("rst_rx_data", o_rx_data, 8'h00);
        check("rst_rx_valid", o_rx_valid, 0);
        check("rst_tx_ready", o_tx_ready, 1);
        check("rst_busy", o_busy, 0);
        i_rst_n = 1'b1;
        wait_cycles(4);
        check("post_rst_busy", o_busy, 0);
        check("post_rst_tx_ready", o_tx_ready, 1);

        // Single byte, 8-cycle SCLK period: TX 0xA5, RX 0x3C
        load_byte(8'hA5);
        wait_cycles(1);
        check("tx_ready_after_load", o_tx_ready, 0);
        run_frame(1, 4, 24'h00003C, 3'b000, 24'h0);

        // Minimum SCLK period, two back-to-back bytes, buffer refilled with 0xC3
        b0 = 8'($urandom);
        load_byte(b0);
        run_frame(2, 2, 24'h007E81, 3'b001, 24'h0000C3);

        // CS raised after 5 SCLK rises; a byte loaded in the window is retained
        rx_before = o_rx_data;
        rx_q.delete();
        i_cs_n = 1'b0;
        wait_cycles(4);
        exp_tx = take_buf();
        drive_byte(8'($urandom), 3, 5, 1'b1, 8'h96, got_tx);
        check("abort_miso_bits", got_tx[7:3], exp_tx[7:3]);
        wait_cycles(1);
        i_cs_n = 1'b1;
        wait_cycles(4);
        check("abort_busy", o_busy, 0);
        wait_cycles(4);
        check("abort_rx_valid_count", rx_q.size(), 0);
        check("abort_rx_data_kept", o_rx_data, rx_before);
        check("abort_tx_ready", o_tx_ready, !model_full);
        run_frame(1, 3, 24'($urandom), 3'b000, 24'h0);   // sends retained 0x96

        // Empty buffer sends 0x00; a load while not ready is ignored
        run_frame(1, 3, 24'($urandom), 3'b000, 24'h0);
        load_byte(8'h5B);
        wait_cycles(1);
        check("ready_low_after_load", o_tx_ready, 0);
        load_byte(8'hE4);
        wait_cycles(1);
        check("ready_low_after_ignored", o_tx_ready, 0);
        run_frame(1, 2, 24'($urandom), 3'b000, 24'h0);   // sends 0x5B

        // Reset pulsed after the 3rd SCLK rise
        rx_q.delete();
        i_cs_n = 1'b0;
        wait_cycles(4);
        void'(take_buf());
        drive_byte(8'($urandom), 3, 3, 1'b0, 8'h00, got_tx);
        wait_cycles(1);
        i_rst_n    = 1'b0;
        model_full = 1'b0;
        wait_cycles(2);
        check("midrst_rx_data", o_rx_data, 8'h00);
        check("midrst_busy", o_busy, 0);
        check("midrst_miso", o_miso, 0);
        i_cs_n = 1'b1;
        i_mosi = 1'b0;
        wait_cycles(2);
        i_rst_n = 1'b1;
        wait_cycles(8);
        check("midrst_idle_after_release", o_busy, 0);
        check("midrst_rx_valid_count", rx_q.size(), 0);
        check("midrst_rx_data_after", o_rx_data, 8'h00);
        check("midrst_tx_ready", o_tx_ready, 1);
        run_frame(1, 3, 24'($urandom), 3'b000, 24'h0);

        // Randomized frames against the byte-level model
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 1) == 1) load_byte(8'($urandom));
            run_frame($urandom_range(1, 3), $urandom_range(2, 5), 24'($urandom),
                      3'($urandom), 24'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
